data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 32 +++
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory responder.
//   - state_t      : responder FSM states
//   - LATENCY_MIN/LATENCY_MAX : legal range of the response latency
//   - CNT_W        : width of the latency down-counter
//   - idx_width()  : storage index width for a given depth (never below 1)
package dmem_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32-bit word storage.
// Synchronous write, combinational read, no reset (contents survive rst).
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write word index
//   wdata  in   write data
//   raddr  in   read word index
//   rdata  out  read data (combinational)
module dmem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding word memory responder with a fixed
// response latency of LATENCY cycles from accept to the one-cycle resp_valid.
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- when defined, a request with
// req_addr[1:0] != 0 completes with resp_err=1; otherwise the low bits are ignored.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  request can be accepted this cycle
//   req_write   in   1 = store, 0 = load
//   req_addr    in   byte address (word index = req_addr[31:2])
//   req_wdata   in   store data
//   resp_valid  out  one-cycle response strobe
//   resp_rdata  out  load data; 0 for stores, errors and outside RESP
//   resp_err    out  request rejected (out of range / misaligned)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction in flight; ready to accept
// WAIT  | request latched; counter counting down to the response cycle
// RESP  | response cycle; store commits on exit; may accept the next request
import dmem_pkg::*;

module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = idx_width(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_latency_check
        $error("data_mem_responder: LATENCY=%0d outside %0d..%0d",
               LATENCY, LATENCY_MIN, LATENCY_MAX);
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;

    logic              accept;
    logic              err;
    logic              mem_we;
    logic [29:0]       word_idx;
    logic [31:0]       mem_rdata;

    assign req_ready = !rst && (state != WAIT);
    assign accept    = req_valid && req_ready;
    assign word_idx  = lat_addr[31:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign err = (word_idx >= 30'(DEPTH_WORDS)) || (lat_addr[1:0] != 2'b00);
`else
    logic unused_align_bits;
    assign unused_align_bits = ^lat_addr[1:0];
    assign err = (word_idx >= 30'(DEPTH_WORDS));
`endif

    // Gate with rst so an edge that coincides with reset never commits.
    assign mem_we = (state == RESP) && lat_write && !err && !rst;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (word_idx[AW-1:0]),
        .wdata (lat_wdata),
        .raddr (word_idx[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err;
    assign resp_rdata = (resp_valid && !err && !lat_write) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int NI = 3;   // instance 0: LATENCY=2, 1: LATENCY=4, 2: LATENCY=1

    typedef struct {
        int          due;
        logic        wr;
        logic        err;
        logic        chk;
        logic [31:0] data;
        logic [31:0] wdata;
        int          idx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_write  [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic        resp_valid [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];

    int tests_run = 0;
    int fails     = 0;
    int cyc       = 0;
    int resp_count [NI];

    exp_t        sb    [NI][$];
    logic [31:0] mdl   [NI][64];
    bit          known [NI][64];

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 4 : 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH_WORDS (64),
            .LATENCY     ((g == 0) ? 2 : (g == 1) ? 4 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: responses are checked before new accepts are pushed,
    // so a load accepted in a store's RESP cycle sees the stored data.
    always @(negedge clk) begin
        if (rst) begin
            for (int g = 0; g < NI; g++) sb[g].delete();
        end else begin
            for (int g = 0; g < NI; g++) begin
                if (resp_valid[g]) begin
                    resp_count[g]++;
                    if (sb[g].size() == 0) begin
                        tests_run++; fails++;
                        $display("FAIL spurious_resp inst=%0d cyc=%0d", g, cyc);
                    end else begin
                        exp_t e;
                        e = sb[g].pop_front();
                        tests_run++;
                        if (cyc !== e.due) begin
                            fails++;
                            $display("FAIL resp_timing inst=%0d got cyc=%0d want cyc=%0d", g, cyc, e.due);
                        end
                        tests_run++;
                        if (resp_err[g] !== e.err) begin
                            fails++;
                            $display("FAIL resp_err inst=%0d cyc=%0d got=%0b want=%0b", g, cyc, resp_err[g], e.err);
                        end
                        if (e.chk) begin
                            tests_run++;
                            if (resp_rdata[g] !== e.data) begin
                                fails++;
                                $display("FAIL resp_rdata inst=%0d cyc=%0d got=%08h want=%08h", g, cyc, resp_rdata[g], e.data);
                            end
                        end
                        if (e.wr && !e.err) begin
                            mdl[g][e.idx]   = e.wdata;
                            known[g][e.idx] = 1'b1;
                        end
                    end
                end else begin
                    tests_run++;
                    if (resp_rdata[g] !== 32'h0 || resp_err[g] !== 1'b0) begin
                        fails++;
                        $display("FAIL idle_outputs inst=%0d cyc=%0d got rdata=%08h err=%0b want 0/0", g, cyc, resp_rdata[g], resp_err[g]);
                    end
                    if (sb[g].size() > 0 && sb[g][0].due < cyc) begin
                        tests_run++; fails++;
                        $display("FAIL missing_resp inst=%0d got none want cyc=%0d", g, sb[g][0].due);
                        void'(sb[g].pop_front());
                    end
                end
                if (req_valid[g] && req_ready[g]) begin
                    exp_t e;
                    e.due   = cyc + lat_of(g);
                    e.wr    = req_write[g];
                    e.err   = (req_addr[g][31:2] >= 30'd64);
`ifdef DMEM_ALIGN_CHECK_EN
                    if (req_addr[g][1:0] != 2'b00) e.err = 1'b1;
`endif
                    e.idx   = e.err ? 0 : int'(req_addr[g][7:2]);
                    e.wdata = req_wdata[g];
                    e.data  = 32'h0;
                    e.chk   = 1'b1;
                    if (!e.err && !e.wr) begin
                        if (known[g][e.idx]) e.data = mdl[g][e.idx];
                        else e.chk = 1'b0;
                    end
                    sb[g].push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    // Present a request and return one cycle after its accept edge with
    // req_valid still high; the caller either issues again or drops it.
    task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
        int n;
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            step();
            n++;
        end
        tests_run++;
        if (n >= 50) begin
            fails++;
            $display("FAIL accept_timeout inst=%0d addr=%08h got ready=0 want 1", d, a);
        end
        step();
    endtask

    task automatic drop(input int d);
        req_valid[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if (req_ready[g] !== 1'b0) begin
                fails++; $display("FAIL reset_ready inst=%0d got=%0b want=0", g, req_ready[g]);
            end
            tests_run++;
            if (resp_valid[g] !== 1'b0 || resp_rdata[g] !== 32'h0 || resp_err[g] !== 1'b0) begin
                fails++; $display("FAIL reset_resp inst=%0d got v=%0b d=%08h e=%0b want 0", g, resp_valid[g], resp_rdata[g], resp_err[g]);
            end
        end
        wait_cycles(2);
        rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if (req_ready[g] !== 1'b1) begin
                fails++; $display("FAIL release_ready inst=%0d got=%0b want=1", g, req_ready[g]);
            end
        end
        step();
    endtask

    task automatic test_store_load();
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF); drop(0);
        wait_cycles(4);
        issue(0, 1'b0, 32'h10, 32'h0); drop(0);
        wait_cycles(4);
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        issue(0, 1'b1, 32'h20, 32'h12345678);
        t0 = cyc;
        issue(0, 1'b0, 32'h20, 32'h0);
        t1 = cyc;
        drop(0);
        tests_run++;
        if (t1 - t0 !== 2) begin
            fails++; $display("FAIL b2b_spacing got=%0d want=2", t1 - t0);
        end
        wait_cycles(4);
    endtask

    task automatic test_out_of_range();
        issue(0, 1'b1, 32'hFC, 32'h5A5A5A5A);  drop(0); wait_cycles(3);
        issue(0, 1'b1, 32'h100, 32'hFFFFFFFF); drop(0); wait_cycles(3);
        issue(0, 1'b0, 32'hFC, 32'h0);         drop(0); wait_cycles(3);
        issue(0, 1'b0, 32'h104, 32'h0);        drop(0); wait_cycles(3);
    endtask

    task automatic test_misaligned();
        issue(0, 1'b0, 32'h13, 32'h0); drop(0); wait_cycles(3);
        issue(0, 1'b1, 32'h11, 32'hCAFEF00D); drop(0); wait_cycles(3);
        issue(0, 1'b0, 32'h10, 32'h0); drop(0); wait_cycles(3);
    endtask

    task automatic test_reset_abandon();
        issue(1, 1'b1, 32'h08, 32'h11111111); drop(1);
        wait_cycles(6);
        issue(1, 1'b1, 32'h08, 32'hAAAA5555); drop(1);
        step();
        rst = 1'b1;
        #1;
        tests_run++;
        if (req_ready[1] !== 1'b0) begin
            fails++; $display("FAIL rst_mid_ready got=%0b want=0", req_ready[1]);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (resp_valid[1] !== 1'b0) begin
                fails++; $display("FAIL abandoned_resp cyc=%0d got=1 want=0", cyc);
            end
            step();
        end
        issue(1, 1'b0, 32'h08, 32'h0); drop(1);
        wait_cycles(6);
    endtask

    task automatic test_throughput();
        int c0;
        for (int i = 0; i < 8; i++) begin
            issue(2, 1'b1, 32'h40 + 32'(4 * i), 32'h0BAD0000 + 32'(i)); drop(2);
            step();
        end
        c0 = resp_count[2];
        for (int i = 0; i < 8; i++) begin
            req_valid[2] = 1'b1;
            req_write[2] = 1'b0;
            req_addr[2]  = 32'h40 + 32'(4 * i);
            tests_run++;
            if (req_ready[2] !== 1'b1) begin
                fails++; $display("FAIL stream_ready i=%0d got=%0b want=1", i, req_ready[2]);
            end
            step();
        end
        drop(2);
        wait_cycles(3);
        tests_run++;
        if (resp_count[2] - c0 !== 8) begin
            fails++; $display("FAIL stream_resp_count got=%0d want=8", resp_count[2] - c0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 16'h10F));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            issue(0, 1'($urandom_range(0, 1)), a, $urandom);
        end
        drop(0);
        wait_cycles(4);
    endtask

    initial begin
        rst = 1'b0;
        for (int g = 0; g < NI; g++) begin
            req_valid[g]  = 1'b0;
            req_write[g]  = 1'b0;
            req_addr[g]   = 32'h0;
            req_wdata[g]  = 32'h0;
            resp_count[g] = 0;
        end
        test_reset();
        test_store_load();
        test_back_to_back();
        test_out_of_range();
        test_misaligned();
        test_reset_abandon();
        test_throughput();
        test_random();
        wait_cycles(20);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
